// File: rtl/register_fetch_forward_if.sv
// register_fetch_forward_if
// Bundles the register-fetch stage's issue, forwarding, write-back and
// output-bundle signals.
//   master : upstream/issue side. Drives in_*, stall, flush, fwd_*, wb_*
//            and receives the registered bundle.
//   slave  : the register-fetch stage itself.
// Signal summary:
//   in_op_code[10:0], in_instr_format[2:0], in_r{a,b,c,t}_addr, in_imm[17:0],
//   in_reg_write                 : decoded instruction from issue
//   stall, flush                 : per-cycle hold / squash controls
//   fwd_data/fwd_addr/fwd_we     : forwarding taps, tap 0 youngest, flattened
//   wb_data/wb_reg_addr/wb_enable_reg_write : write-back port
//   op_code .. store_reg         : registered bundle to Simple_Fixed_1
interface register_fetch_forward_if #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7,
  parameter int FWD_DEPTH = 3
) ();
  logic [10:0]                  in_op_code;
  logic [2:0]                   in_instr_format;
  logic [ADDR_W-1:0]            in_ra_addr;
  logic [ADDR_W-1:0]            in_rb_addr;
  logic [ADDR_W-1:0]            in_rc_addr;
  logic [ADDR_W-1:0]            in_rt_addr;
  logic [17:0]                  in_imm;
  logic                         in_reg_write;
  logic                         stall;
  logic                         flush;
  logic [FWD_DEPTH*DATA_W-1:0]  fwd_data;
  logic [FWD_DEPTH*ADDR_W-1:0]  fwd_addr;
  logic [FWD_DEPTH-1:0]         fwd_we;
  logic [DATA_W-1:0]            wb_data;
  logic [ADDR_W-1:0]            wb_reg_addr;
  logic                         wb_enable_reg_write;

  logic [10:0]                  op_code;
  logic [2:0]                   instr_format;
  logic [ADDR_W-1:0]            dest_reg_addr;
  logic [17:0]                  imm_value;
  logic                         enable_reg_write;
  logic [DATA_W-1:0]            src_reg_a;
  logic [DATA_W-1:0]            src_reg_b;
  logic [DATA_W-1:0]            store_reg;

  modport master (
    output in_op_code, in_instr_format, in_ra_addr, in_rb_addr, in_rc_addr,
           in_rt_addr, in_imm, in_reg_write, stall, flush,
           fwd_data, fwd_addr, fwd_we,
           wb_data, wb_reg_addr, wb_enable_reg_write,
    input  op_code, instr_format, dest_reg_addr, imm_value, enable_reg_write,
           src_reg_a, src_reg_b, store_reg
  );

  modport slave (
    input  in_op_code, in_instr_format, in_ra_addr, in_rb_addr, in_rc_addr,
           in_rt_addr, in_imm, in_reg_write, stall, flush,
           fwd_data, fwd_addr, fwd_we,
           wb_data, wb_reg_addr, wb_enable_reg_write,
    output op_code, instr_format, dest_reg_addr, imm_value, enable_reg_write,
           src_reg_a, src_reg_b, store_reg
  );
endinterface

// File: rtl/register_fetch_forward.sv
// register_fetch_forward
// Register-fetch stage of the SPU even pipe. Reads three operands (ra, rb,
// rc) from the 128 x 128-bit register file, overrides them with in-flight
// results from the forwarding taps or the write-back port, and registers the
// issue bundle consumed by Simple_Fixed_1.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears the bundle and the array
//   bus   : register_fetch_forward_if.slave (issue, forwarding, write-back,
//           registered bundle)
module register_fetch_forward #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 7,
  parameter int FWD_DEPTH = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  register_fetch_forward_if.slave bus
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register file; reset clears it so a reset mid-stream discards all state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_enable_reg_write) begin
      regs[bus.wb_reg_addr] <= bus.wb_data;
    end
  end

  logic [ADDR_W-1:0] src_addr [3];
  logic [DATA_W-1:0] src_val  [3];

  assign src_addr[0] = bus.in_ra_addr;
  assign src_addr[1] = bus.in_rb_addr;
  assign src_addr[2] = bus.in_rc_addr;

  // Operand select, one copy per source. Array is the fallback, write-back
  // overrides it (write-through), then taps are scanned from the oldest down
  // to tap 0 so the youngest matching tap is the last assignment and wins.
  for (genvar s = 0; s < 3; s++) begin : g_src
    always_comb begin
      src_val[s] = regs[src_addr[s]];
      if (bus.wb_enable_reg_write && (bus.wb_reg_addr == src_addr[s])) begin
        src_val[s] = bus.wb_data;
      end
      for (int t = FWD_DEPTH - 1; t >= 0; t--) begin
        if (bus.fwd_we[t] && (bus.fwd_addr[t*ADDR_W +: ADDR_W] == src_addr[s])) begin
          src_val[s] = bus.fwd_data[t*DATA_W +: DATA_W];
        end
      end
    end
  end

  logic [10:0]       op_code_q;
  logic [2:0]        instr_format_q;
  logic [ADDR_W-1:0] dest_reg_addr_q;
  logic [17:0]       imm_value_q;
  logic              enable_reg_write_q;
  logic [DATA_W-1:0] src_reg_a_q;
  logic [DATA_W-1:0] src_reg_b_q;
  logic [DATA_W-1:0] store_reg_q;

  // Bundle register. Flush beats stall: a squashed slot becomes an all-zero
  // nop. A stalled bundle keeps its operands even if write-back hits one of
  // its sources; upstream re-presents the instruction and re-reads them.
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      op_code_q          <= '0;
      instr_format_q     <= '0;
      dest_reg_addr_q    <= '0;
      imm_value_q        <= '0;
      enable_reg_write_q <= 1'b0;
      src_reg_a_q        <= '0;
      src_reg_b_q        <= '0;
      store_reg_q        <= '0;
    end else if (!bus.stall) begin
      op_code_q          <= bus.in_op_code;
      instr_format_q     <= bus.in_instr_format;
      dest_reg_addr_q    <= bus.in_rt_addr;
      imm_value_q        <= bus.in_imm;
      enable_reg_write_q <= bus.in_reg_write;
      src_reg_a_q        <= src_val[0];
      src_reg_b_q        <= src_val[1];
      store_reg_q        <= src_val[2];
    end
  end

  assign bus.op_code          = op_code_q;
  assign bus.instr_format     = instr_format_q;
  assign bus.dest_reg_addr    = dest_reg_addr_q;
  assign bus.imm_value        = imm_value_q;
  assign bus.enable_reg_write = enable_reg_write_q;
  assign bus.src_reg_a        = src_reg_a_q;
  assign bus.src_reg_b        = src_reg_b_q;
  assign bus.store_reg        = store_reg_q;

endmodule

// File: tb/tb_register_fetch_forward.sv
// tb_register_fetch_forward
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the register file and the issue bundle.
module tb_register_fetch_forward;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int FD = 3;

  logic clock = 1'b0;
  logic reset;

  register_fetch_forward_if #(.DATA_W(DW), .ADDR_W(AW), .FWD_DEPTH(FD)) bus ();

  register_fetch_forward #(.DATA_W(DW), .ADDR_W(AW), .FWD_DEPTH(FD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [DW-1:0] mem [128];
  logic [10:0]   e_op;
  logic [2:0]    e_fmt;
  logic [6:0]    e_rt;
  logic [17:0]   e_imm;
  logic          e_we;
  logic [DW-1:0] e_a, e_b, e_c;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Operand as the spec defines it: youngest matching tap, else write-back,
  // else the stored value.
  function automatic logic [DW-1:0] model_read(input logic [6:0] a);
    for (int i = 0; i < FD; i++) begin
      if (bus.fwd_we[i] && bus.fwd_addr[i*AW +: AW] == a) return bus.fwd_data[i*DW +: DW];
    end
    if (bus.wb_enable_reg_write && bus.wb_reg_addr == a) return bus.wb_data;
    return mem[a];
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle();
    bus.in_op_code = '0; bus.in_instr_format = '0;
    bus.in_ra_addr = '0; bus.in_rb_addr = '0; bus.in_rc_addr = '0; bus.in_rt_addr = '0;
    bus.in_imm = '0; bus.in_reg_write = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.fwd_data = '0; bus.fwd_addr = '0; bus.fwd_we = '0;
    bus.wb_data = '0; bus.wb_reg_addr = '0; bus.wb_enable_reg_write = 1'b0;
  endtask

  task automatic set_tap(input int i, input logic [6:0] a, input logic [DW-1:0] d);
    bus.fwd_we[i] = 1'b1;
    bus.fwd_addr[i*AW +: AW] = a;
    bus.fwd_data[i*DW +: DW] = d;
  endtask

  task automatic set_wb(input logic [6:0] a, input logic [DW-1:0] d);
    bus.wb_enable_reg_write = 1'b1;
    bus.wb_reg_addr = a;
    bus.wb_data = d;
  endtask

  // Predict one edge from the current inputs, clock it, then compare.
  task automatic step();
    logic [DW-1:0] ra_v, rb_v, rc_v;
    ra_v = model_read(bus.in_ra_addr);
    rb_v = model_read(bus.in_rb_addr);
    rc_v = model_read(bus.in_rc_addr);
    if (reset || bus.flush) begin
      e_op = '0; e_fmt = '0; e_rt = '0; e_imm = '0; e_we = 1'b0;
      e_a = '0; e_b = '0; e_c = '0;
    end else if (!bus.stall) begin
      e_op = bus.in_op_code; e_fmt = bus.in_instr_format; e_rt = bus.in_rt_addr;
      e_imm = bus.in_imm; e_we = bus.in_reg_write;
      e_a = ra_v; e_b = rb_v; e_c = rc_v;
    end
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
    end else if (bus.wb_enable_reg_write) begin
      mem[bus.wb_reg_addr] = bus.wb_data;
    end
    @(posedge clock);
    #1;
    chk("op_code",      DW'(bus.op_code),          DW'(e_op));
    chk("instr_format", DW'(bus.instr_format),     DW'(e_fmt));
    chk("dest_reg",     DW'(bus.dest_reg_addr),    DW'(e_rt));
    chk("imm_value",    DW'(bus.imm_value),        DW'(e_imm));
    chk("enable_we",    DW'(bus.enable_reg_write), DW'(e_we));
    chk("src_reg_a",    bus.src_reg_a,             e_a);
    chk("src_reg_b",    bus.src_reg_b,             e_b);
    chk("store_reg",    bus.store_reg,             e_c);
  endtask

  localparam logic [10:0] OP_AH  = 11'b00011001000;
  localparam logic [10:0] OP_AND = 11'b00011000001;
  localparam logic [10:0] OP_SF  = 11'b00001000000;
  localparam logic [10:0] OP_ILA = 11'b01000010000;

  initial begin
    logic [DW-1:0] v3, v3b, va, vb, vc, vd;
    logic [10:0]   held_op;
    logic [DW-1:0] held_a;
    v3  = 128'h1A2B3C4D_5E6F7081_92A3B4C5_D6E7F5C6;
    v3b = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
    va  = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0001;
    vb  = 128'hBBBB_1111_BBBB_1111_BBBB_1111_BBBB_0002;
    vc  = 128'hCCCC_2222_CCCC_2222_CCCC_2222_CCCC_0003;
    vd  = 128'hDDDD_3333_DDDD_3333_DDDD_3333_DDDD_0004;
    for (int i = 0; i < 128; i++) mem[i] = rnd128();
    idle();

    // Reset
    reset = 1'b1;
    step();
    chk("rst_op", DW'(bus.op_code), '0);
    chk("rst_we", DW'(bus.enable_reg_write), '0);
    reset = 1'b0;
    bus.in_ra_addr = 7'd5; bus.in_rb_addr = 7'd127;
    step();
    chk("rst_rd_a", bus.src_reg_a, '0);
    chk("rst_rd_b", bus.src_reg_b, '0);

    // Write then read, and read-during-write
    idle(); set_wb(7'd3, v3); step();
    idle(); bus.in_op_code = OP_AH; bus.in_ra_addr = 7'd3; bus.in_reg_write = 1'b1; step();
    chk("wr_rd_r3", bus.src_reg_a, v3);
    set_wb(7'd3, v3b); step();
    chk("rdw_r3", bus.src_reg_a, v3b);

    // Forward priority
    idle(); set_wb(7'd7, va); step();
    idle(); bus.in_ra_addr = 7'd7; bus.in_rb_addr = 7'd7; bus.in_rc_addr = 7'd7;
    set_wb(7'd7, vb); set_tap(2, 7'd7, vc); set_tap(0, 7'd7, vd);
    step();
    chk("fwd_tap0_a", bus.src_reg_a, vd);
    chk("fwd_tap0_b", bus.src_reg_b, vd);
    chk("fwd_tap0_c", bus.store_reg, vd);
    bus.fwd_we[0] = 1'b0; step();
    chk("fwd_tap2", bus.src_reg_a, vc);
    bus.fwd_we = '0; step();
    chk("fwd_wb", bus.src_reg_a, vb);

    // Stall
    idle(); bus.in_op_code = OP_AND; bus.in_ra_addr = 7'd3; bus.in_rt_addr = 7'd4;
    bus.in_reg_write = 1'b1; step();
    held_op = bus.op_code; held_a = bus.src_reg_a;
    for (int k = 0; k < 2; k++) begin
      bus.stall = 1'b1; bus.in_op_code = OP_AH ^ 11'(k); bus.in_rt_addr = 7'(20 + k);
      set_wb(7'd3, rnd128());
      step();
      chk("stall_op", DW'(bus.op_code), DW'(OP_AND));
      chk("stall_a", bus.src_reg_a, v3b);
    end
    idle(); bus.in_op_code = OP_AH; bus.in_ra_addr = 7'd3; bus.in_rt_addr = 7'd22;
    bus.in_reg_write = 1'b1; step();
    chk("unstall_op", DW'(bus.op_code), DW'(OP_AH));

    // Flush with stall
    idle(); bus.in_op_code = OP_SF; bus.in_reg_write = 1'b1; bus.in_rt_addr = 7'd8;
    bus.stall = 1'b1; bus.flush = 1'b1; step();
    chk("flush_op", DW'(bus.op_code), '0);
    chk("flush_we", DW'(bus.enable_reg_write), '0);
    bus.stall = 1'b0; bus.flush = 1'b0; step();
    chk("post_flush_op", DW'(bus.op_code), DW'(OP_SF));

    // Immediate format
    idle(); bus.in_op_code = OP_ILA; bus.in_instr_format = 3'd6;
    bus.in_imm = 18'b000110011001100110; bus.in_rt_addr = 7'd9; bus.in_reg_write = 1'b1;
    step();
    chk("ila_imm", DW'(bus.imm_value), DW'(18'b000110011001100110));
    chk("ila_rt",  DW'(bus.dest_reg_addr), DW'(7'd9));
    chk("ila_fmt", DW'(bus.instr_format), DW'(3'd6));

    // Randomized traffic, addresses narrowed to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      reset = ($urandom_range(0, 99) == 0);
      bus.in_op_code = 11'($urandom); bus.in_instr_format = 3'($urandom);
      bus.in_ra_addr = 7'($urandom_range(0, 7)); bus.in_rb_addr = 7'($urandom_range(0, 7));
      bus.in_rc_addr = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
      bus.in_rt_addr = 7'($urandom); bus.in_imm = 18'($urandom); bus.in_reg_write = 1'($urandom);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      for (int t = 0; t < FD; t++) begin
        if ($urandom_range(0, 2) == 0) set_tap(t, 7'($urandom_range(0, 7)), rnd128());
        else begin
          bus.fwd_addr[t*AW +: AW] = 7'($urandom_range(0, 7));
          bus.fwd_data[t*DW +: DW] = rnd128();
        end
      end
      if ($urandom_range(0, 1) == 0) set_wb(7'($urandom_range(0, 7)), rnd128());
      else begin
        bus.wb_reg_addr = 7'($urandom_range(0, 7));
        bus.wb_data = rnd128();
      end
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_fetch_forward.md
# register_fetch_forward

Register-fetch stage of the SPU even pipe. It reads three 128-bit source operands from the 128-entry register file, overrides them with in-flight results from the forwarding network, and registers the full issue bundle that the Simple_Fixed_1 execution unit consumes. The write-back port from the end of the pipe updates the array.

## Interface
Parameters:
- DATA_W, 128: register width.
- ADDR_W, 7: register address width (128 entries).
- FWD_DEPTH, 3: number of forwarding taps. Tap 0 is the youngest.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- in_op_code  in  11  decoded opcode, left-aligned per format.
- in_instr_format  in  3  instruction format.
- in_ra_addr, in_rb_addr, in_rc_addr  in  7 each  source register addresses. rc is the store/third operand.
- in_rt_addr  in  7  destination register address.
- in_imm  in  18  immediate value.
- in_reg_write  in  1  instruction writes rt.
- stall  in  1  hold the output bundle.
- flush  in  1  branch taken; squash the bundle.
- fwd_data  in  FWD_DEPTH*128  forwarding tap data, flattened, tap 0 at bits [0:127].
- fwd_addr  in  FWD_DEPTH*7  forwarding tap destination addresses.
- fwd_we  in  FWD_DEPTH  forwarding tap valid/write flags.
- wb_data  in  128  write-back data.
- wb_reg_addr  in  7  write-back address.
- wb_enable_reg_write  in  1  write-back enable.
- op_code, instr_format, dest_reg_addr, imm_value, enable_reg_write  out  11/3/7/18/1  registered bundle to Simple_Fixed_1.
- src_reg_a, src_reg_b, store_reg  out  128 each  registered operands.

## Operation
- Array: 128 × 128-bit.
  - Written on the clock edge when wb_enable_reg_write=1.
  - There is no hardwired-zero register.
  - Reset clears every entry to 0.
- Operand select, applied per source independently, in highest-priority-first order:
  1. Lowest-index tap i with fwd_we[i]=1 and fwd_addr[i] equal to the source address.
  2. The write-back port, when wb_enable_reg_write=1 and wb_reg_addr matches (write-through).
  3. The array entry.
- Immediate and opcode fields pass through unmodified. Sign/zero extension belongs to the execution unit.
- Bundle register update, per edge, in priority order:
  1. reset=1: all outputs 0.
  2. flush=1: op_code=0 (nop) and enable_reg_write=0. Other fields are don't-care and driven 0. Flush wins over stall.
  3. stall=1: all outputs hold their values. The array still accepts write-back.
  4. Otherwise: load the selected operands and the in_* fields.
- A write-back arriving while the stage is stalled does not refresh held operands. Upstream re-presents the instruction after a stall, so the operands are re-read then.

## Timing
- Reset values:
  - Every output is 0, which is a nop bundle with enable_reg_write=0.
  - The array is all zeros.
  - reset is sampled on clock. An asserted reset in the middle of a stream discards the bundle in flight and the array contents.
- Latency: inputs sampled at edge N appear on the outputs after edge N and stay stable until edge N+1.
- Read-during-write to the same address in the same cycle returns the new wb_data. The array holds the new value from edge N onward.
- A tap and write-back to the same address in the same cycle: the tap wins.
- Two taps to the same address: the lowest index wins.
- Addresses wrap naturally at 7 bits; no out-of-range case exists.
- There is no internal state machine beyond the array and the bundle register. Stall and flush are level-sensitive per cycle.

## Test plan
- **Reset:** hold reset 1 cycle, then read ra=5, rb=127 with no write-back → src_reg_a=0, src_reg_b=0, op_code=0, enable_reg_write=0.
- **Write then read:**
  - Write r3=128'h1A2B…5C6 via write-back, then issue ah (11'b00011001000) with ra=3 → src_reg_a=128'h1A2B…5C6 one cycle later.
  - Read r3 in the same cycle as its write-back → the new value, not the old one.
- **Forward priority:**
  - r7 in the array = A.
  - Same cycle: wb writes r7=B, tap2 r7=C, tap0 r7=D. Read ra=rb=rc=7 → all three outputs = D.
  - Drop tap0 → C. Drop all taps → B.
- **Stall:**
  - Issue and (11'b00011000001), then assert stall 2 cycles while changing the in_* fields and writing back to ra → outputs unchanged for both cycles.
  - Release stall → the new bundle appears.
- **Flush:**
  - Assert flush and stall together with a valid sf → op_code=0, enable_reg_write=0.
  - The next unflushed instruction issues normally.
- **Immediate formats:** ila, format 6, imm=18'b000110011001100110, rt=9 → imm_value equals the input bits, dest_reg_addr=9, instr_format=6.
